// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle instruction control unit: opcodes,
// FSM states, instruction classes and the datapath strobe bundle.
package uc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Branch-flag mux selects that are not plain funct3 comparisons.
    localparam logic [2:0] SEL_SEQ    = 3'b010;
    localparam logic [2:0] SEL_ALWAYS = 3'b011;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        PC_UPD,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } instr_class_t;

    typedef struct packed {
        logic       we_reg;
        logic       we_mem;
        logic [1:0] op_mem_i;
        logic       add_sub;
        logic       pc_load;
        logic [2:0] select_flags;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '{
        we_reg:       1'b0,
        we_mem:       1'b0,
        op_mem_i:     WB_ALU,
        add_sub:      1'b0,
        pc_load:      1'b0,
        select_flags: SEL_SEQ
    };

    // Strobes the datapath sees while the FSM sits in state s.
    function automatic strobes_t strobes_for(
        input state_t       s,
        input instr_class_t cls,
        input logic [2:0]   funct3,
        input logic         funct7_b5,
        input logic         mem_first,
        input logic         mem_last
    );
        strobes_t st;
        st = STROBES_IDLE;
        case (s)
            EXEC: begin
                st.add_sub = (cls == CLS_R && funct3 == 3'b000 && funct7_b5)
                           || (cls == CLS_BRANCH);
                st.we_reg  = (cls == CLS_R) || (cls == CLS_I);
            end
            MEM: begin
                if (cls == CLS_STORE) begin
                    st.we_mem = mem_first;
                end else if (cls == CLS_LOAD) begin
                    st.op_mem_i = WB_MEM;
                    st.we_reg   = mem_last;
                end
            end
            PC_UPD: begin
                st.pc_load      = 1'b1;
                st.select_flags = (cls == CLS_BRANCH) ? funct3 : SEL_SEQ;
            end
            default: ;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational opcode classifier: maps opcode/funct3 to an instruction
// class and flags encodings the datapath cannot execute.
module uc_decoder
    import uc_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output instr_class_t cls,
    output logic         legal
);

    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        cls   = CLS_NONE;
        legal = 1'b1;
        case (opcode)
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: begin
                cls   = CLS_BRANCH;
                // funct3 010/011 have no branch-flag comparison behind them.
                legal = !(funct3 == 3'b010 || funct3 == 3'b011);
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_uc.sv
// Multicycle control unit: walks each ROM word through FETCH, DECODE, EXEC,
// optional MEM and PC_UPD, driving registered datapath strobes.
module instruction_uc
    import uc_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [31:0]        instruction,
    output logic               WE_reg,
    output logic               WE_mem,
    output logic [1:0]         OP_MEM_I,
    output logic               ADD_SUB,
    output logic               PC_load,
    output logic [2:0]         select_flags,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LAT - 1);

    state_t             state, state_d;
    instr_class_t       cls_q, cls_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               funct7_b5_q, funct7_b5_d;
    logic [CNT_W-1:0]   mem_cnt, mem_cnt_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] count_q;
    strobes_t           strobes_q, strobes_d;

    instr_class_t       dec_cls;
    logic               dec_legal;
    logic               unused_instr;

    assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:7]};

    uc_decoder u_decoder (
        .opcode (instruction[6:0]),
        .funct3 (instruction[14:12]),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    always_comb begin
        state_d     = state;
        cls_d       = cls_q;
        funct3_d    = funct3_q;
        funct7_b5_d = funct7_b5_q;
        mem_cnt_d   = mem_cnt;
        illegal_d   = illegal_q;
        case (state)
            IDLE:   if (run) state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                cls_d       = dec_cls;
                funct3_d    = instruction[14:12];
                funct7_b5_d = instruction[30];
                if (!dec_legal) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d   = MEM;
                    mem_cnt_d = '0;
                end else begin
                    state_d = PC_UPD;
                end
            end
            MEM: begin
                mem_cnt_d = mem_cnt + CNT_W'(1);
                if (mem_cnt == MEM_LAST) state_d = PC_UPD;
            end
            PC_UPD: state_d = run ? FETCH : IDLE;
            HALT:   state_d = HALT;
            default: state_d = IDLE;
        endcase

        // NOTE: strobes are computed from the *next* state and fields and then
        // registered, so each output flop changes on the same edge as the state
        // it belongs to and the datapath never sees decode glitches.
        strobes_d = strobes_for(state_d, cls_d, funct3_d, funct7_b5_d,
                                mem_cnt_d == '0, mem_cnt_d == MEM_LAST);
    end

    // NOTE: the asynchronous reset clears every control flop immediately, so
    // an in-flight write strobe drops within the cycle reset is raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cls_q       <= CLS_NONE;
            funct3_q    <= 3'b000;
            funct7_b5_q <= 1'b0;
            mem_cnt     <= '0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
            strobes_q   <= STROBES_IDLE;
        end else begin
            state       <= state_d;
            cls_q       <= cls_d;
            funct3_q    <= funct3_d;
            funct7_b5_q <= funct7_b5_d;
            mem_cnt     <= mem_cnt_d;
            illegal_q   <= illegal_d;
            strobes_q   <= strobes_d;
            if (state == PC_UPD) count_q <= count_q + COUNT_W'(1);
        end
    end

    assign WE_reg       = strobes_q.we_reg;
    assign WE_mem       = strobes_q.we_mem;
    assign OP_MEM_I     = strobes_q.op_mem_i;
    assign ADD_SUB      = strobes_q.add_sub;
    assign PC_load      = strobes_q.pc_load;
    assign select_flags = strobes_q.select_flags;
    assign busy         = (state != IDLE) && (state != HALT);
    assign halted       = (state == HALT);
    assign illegal      = illegal_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_instruction_uc.sv
// Scoreboard bench for instruction_uc: a per-instruction reference model
// queues the expected cycle trace, a negedge monitor pops and compares it.
module tb_instruction_uc;

    localparam int MEM_LAT = 3;
    localparam int COUNT_W = 4;

    localparam logic [6:0] T_OP_R      = 7'b0110011;
    localparam logic [6:0] T_OP_I      = 7'b0010011;
    localparam logic [6:0] T_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] T_OP_STORE  = 7'b0100011;
    localparam logic [6:0] T_OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic               busy;
        logic               halted;
        logic               illegal;
        logic               we_reg;
        logic               we_mem;
        logic [1:0]         op_mem_i;
        logic               add_sub;
        logic               pc_load;
        logic [2:0]         sel;
        logic [COUNT_W-1:0] cnt;
    } obs_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               run = 1'b0;
    logic [31:0]        instruction;
    logic               WE_reg, WE_mem, ADD_SUB, PC_load, busy, halted, illegal;
    logic [1:0]         OP_MEM_I;
    logic [2:0]         select_flags;
    logic [COUNT_W-1:0] instr_count;

    logic [31:0]        rom [64];
    logic [5:0]         pc;
    logic [COUNT_W-1:0] model_count;
    obs_t               exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instruction = rom[pc];

    // Program counter of the surrounding datapath: steps on every PC_load.
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else if (PC_load) pc <= pc + 6'd1;
    end

    instruction_uc #(.MEM_LAT(MEM_LAT), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .instruction  (instruction),
        .WE_reg       (WE_reg),
        .WE_mem       (WE_mem),
        .OP_MEM_I     (OP_MEM_I),
        .ADD_SUB      (ADD_SUB),
        .PC_load      (PC_load),
        .select_flags (select_flags),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal),
        .instr_count  (instr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy     = busy;
        o.halted   = halted;
        o.illegal  = illegal;
        o.we_reg   = WE_reg;
        o.we_mem   = WE_mem;
        o.op_mem_i = OP_MEM_I;
        o.add_sub  = ADD_SUB;
        o.pc_load  = PC_load;
        o.sel      = select_flags;
        o.cnt      = instr_count;
        return o;
    endfunction

    function automatic bit is_legal(input logic [31:0] w);
        logic [6:0] opc;
        opc = w[6:0];
        if (opc == T_OP_BRANCH) return !(w[14:12] == 3'd2 || w[14:12] == 3'd3);
        return opc == T_OP_R || opc == T_OP_I || opc == T_OP_LOAD || opc == T_OP_STORE;
    endfunction

    // Reference model: expected observation for every busy/halted cycle of one
    // instruction. Returns 0 when the instruction halts the machine.
    function automatic bit model_instr(input logic [31:0] w);
        obs_t base, o;
        logic [6:0] opc;
        logic [2:0] f3;
        opc = w[6:0];
        f3  = w[14:12];
        base = '0;
        base.busy = 1'b1;
        base.sel  = 3'b010;
        base.cnt  = model_count;
        exp_q.push_back(base);               // fetch
        exp_q.push_back(base);               // decode
        if (!is_legal(w)) begin
            o = base;
            o.busy    = 1'b0;
            o.halted  = 1'b1;
            o.illegal = 1'b1;
            repeat (4) exp_q.push_back(o);
            return 1'b0;
        end
        o = base;
        o.add_sub = (opc == T_OP_R && f3 == 3'd0 && w[30]) || opc == T_OP_BRANCH;
        o.we_reg  = (opc == T_OP_R || opc == T_OP_I);
        exp_q.push_back(o);                  // execute
        if (opc == T_OP_LOAD || opc == T_OP_STORE) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                o = base;
                if (opc == T_OP_STORE) begin
                    o.we_mem = (i == 0);
                end else begin
                    o.op_mem_i = 2'b01;
                    o.we_reg   = (i == MEM_LAT - 1);
                end
                exp_q.push_back(o);
            end
        end
        o = base;
        o.pc_load = 1'b1;
        o.sel     = (opc == T_OP_BRANCH) ? f3 : 3'b010;
        exp_q.push_back(o);                  // pc update
        model_count = model_count + 1'b1;
        return 1'b1;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        logic [2:0]  br_f3 [6];
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        w = $urandom();
        case ($urandom_range(0, 4))
            0: begin
                w[6:0] = T_OP_R;
                if ($urandom_range(0, 1) == 1) w[14:12] = 3'd0;
            end
            1: w[6:0] = T_OP_I;
            2: w[6:0] = T_OP_LOAD;
            3: w[6:0] = T_OP_STORE;
            default: begin
                w[6:0]   = T_OP_BRANCH;
                w[14:12] = br_f3[$urandom_range(0, 5)];
            end
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 1) == 1) begin
            w[6:0]   = T_OP_BRANCH;
            w[14:12] = {2'b01, 1'($urandom_range(0, 1))};
        end else begin
            while (is_legal(w)) w = $urandom();
        end
        return w;
    endfunction

    // Monitor: compares every busy/halted cycle against the scoreboard and
    // checks that run sampled in PC_UPD decides whether the next cycle is busy.
    bit   saw_pcl = 1'b0;
    logic run_at_pcl = 1'b0;
    obs_t obs, exp_o;

    always @(negedge clk) begin
        if (reset) begin
            saw_pcl = 1'b0;
        end else begin
            obs = sample();
            if (saw_pcl) check("run_after_pc_upd", 64'(busy), 64'(run_at_pcl));
            saw_pcl    = PC_load;
            run_at_pcl = run;
            if (busy || halted) begin
                if (exp_q.size() > 0) begin
                    exp_o = exp_q.pop_front();
                    check("trace", 64'(obs), 64'(exp_o));
                end else if (busy) begin
                    check("unexpected_busy", 64'(busy), 64'd0);
                end
            end else begin
                check("idle_strobes", 64'({WE_reg, WE_mem, OP_MEM_I, ADD_SUB, PC_load, select_flags, illegal}),
                      64'({7'b0, 3'b010, 1'b0}));
            end
        end
    end

    task automatic assert_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check("reset_outputs", 64'(sample()), 64'({3'b000, 7'b0, 3'b010, {COUNT_W{1'b0}}}));
        exp_q.delete();
        model_count = '0;
    endtask

    task automatic load_program(input logic [31:0] prog [$]);
        bit live;
        for (int i = 0; i < 64; i++) rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
        live = 1'b1;
        for (int i = 0; i < prog.size(); i++) if (live) live = model_instr(prog[i]);
    endtask

    task automatic wait_done(input bit rand_run);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #2;
            run = rand_run ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (exp_q.size() == 0 && halted) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL program_timeout: pending %0d halted %0b required 0 and 1", exp_q.size(), halted);
        end
    endtask

    task automatic run_program(input logic [31:0] prog [$], input bit rand_run);
        assert_reset();
        load_program(prog);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        wait_done(rand_run);
    endtask

    task automatic reset_mid_store();
        logic [31:0] prog [$];
        bit found;
        prog = '{32'h002081B3, 32'h402081B3, 32'h00502423, 32'h0000006F};
        assert_reset();
        load_program(prog);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        run   = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (WE_mem === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("store_reached", 64'(found), 64'd1);
        check("count_before_reset", 64'(instr_count), 64'd2);
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_store_we_mem", 64'(WE_mem), 64'd0);
        check("reset_mid_store_state", 64'({busy, halted}), 64'd0);
        check("reset_mid_store_count", 64'(instr_count), 64'd0);
        exp_q.delete();
        model_count = '0;
        load_program(prog);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        run   = 1'b1;
        wait_done(1'b0);
    endtask

    initial begin
        logic [31:0] prog [$];
        model_count = '0;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;

        prog = '{32'h002081B3, 32'h402081B3, 32'h00402283, 32'h00502423,
                 32'h00208463, 32'h0020A063};
        run_program(prog, 1'b0);
        run_program(prog, 1'b1);

        prog = '{32'h00208463, 32'h0000006F};
        run_program(prog, 1'b1);

        reset_mid_store();

        for (int r = 0; r < 6; r++) begin
            prog.delete();
            for (int i = 0; i < 20 + $urandom_range(0, 10); i++) prog.push_back(rand_legal());
            prog.push_back(rand_illegal());
            run_program(prog, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
